// File: rtl/ahbl_rr_sched.sv
// ahbl_rr_sched: round-robin address-phase scheduler for an AHB-Lite
// interconnect.
// It grants one requesting master at a time. A grant that is shown while
// the downstream is stalled stays in place until the address phase
// completes. A port that wins too many times in a row is rotated away from.
// Optional feature: define AHBL_RR_LOCK_EN to keep the bus on a master for
// the whole of an HMASTLOCK sequence.
module ahbl_rr_sched #(
    parameter int                 N_PORTS   = 2,
    parameter logic [N_PORTS-1:0] CONN_MASK = {N_PORTS{1'b1}},
    parameter int                 MAX_HOLD  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] mastlock,
    input  logic               advance,
    output logic [N_PORTS-1:0] gnt,
    output logic [N_PORTS-1:0] gnt_d,
    output logic               locked
);

    localparam int                 PTR_W    = $clog2(N_PORTS);
    localparam int                 HOLD_CAP = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
    localparam int                 CNT_W    = $clog2(HOLD_CAP + 1);
    localparam logic [PTR_W-1:0]   PTR_RST  = PTR_W'(N_PORTS - 1);
    localparam logic [CNT_W-1:0]   CNT_CAP  = CNT_W'(HOLD_CAP);
    localparam logic [N_PORTS-1:0] ONE_HOT0 = {{(N_PORTS-1){1'b0}}, 1'b1};

    logic [N_PORTS-1:0] eligible;
    logic [N_PORTS-1:0] ptr_onehot;
    logic [N_PORTS-1:0] search_mask;
    logic [N_PORTS-1:0] rr_gnt;
    logic [N_PORTS-1:0] hold_gnt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [CNT_W-1:0]   hold_cnt;
    logic               hold_valid;
    logic               force_rotate;
    logic               gnt_any;

    assign eligible   = req & CONN_MASK;
    assign ptr_onehot = ONE_HOT0 << ptr;
    assign gnt_any    = |gnt;

`ifdef AHBL_RR_LOCK_EN
    logic               lock_q;
    logic [PTR_W-1:0]   lock_id;
    logic [N_PORTS-1:0] lock_onehot;

    assign lock_onehot = ONE_HOT0 << lock_id;
    assign locked      = lock_q;
`else
    logic unused_mastlock;

    assign unused_mastlock = ^mastlock;
    assign locked          = 1'b0;
`endif

    // Take the last winner out of the search once it has used up its run
    // of consecutive grants, but only if someone else is waiting.
    always_comb begin
        force_rotate = 1'b0;
        if ((MAX_HOLD != 0) && (hold_cnt == CNT_CAP) &&
            ((eligible & ~ptr_onehot) != '0)) begin
            force_rotate = 1'b1;
        end
        search_mask = force_rotate ? (eligible & ~ptr_onehot) : eligible;
    end

    // Cyclic search that starts just after the last accepted winner, so the
    // last winner is considered last.
    always_comb begin
        int cand;
        rr_gnt = '0;
        cand   = 0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = i + int'(ptr);
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            if ((rr_gnt == '0) && search_mask[PTR_W'(cand)]) begin
                rr_gnt[PTR_W'(cand)] = 1'b1;
            end
        end
    end

    // Pick the grant in order of precedence: a locked sequence first, then a
    // grant that is still stalled, then the round-robin winner.
    always_comb begin
        gnt = rr_gnt;
        if (hold_valid && ((req & hold_gnt) != '0)) begin
            gnt = hold_gnt;
        end
`ifdef AHBL_RR_LOCK_EN
        if (lock_q) begin
            gnt = req[lock_id] ? lock_onehot : '0;
        end
`endif
    end

    // Convert the one-hot grant to a port index for the pointer update.
    always_comb begin
        gnt_idx = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (gnt[p]) begin
                gnt_idx = PTR_W'(p);
            end
        end
    end

    // Record a stalled grant. When the address phase completes, record the
    // winner, the data-phase owner and the length of its run of wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= PTR_RST;
            hold_cnt   <= '0;
            hold_valid <= 1'b0;
            hold_gnt   <= '0;
            gnt_d      <= '0;
        end else begin
            hold_valid <= gnt_any && !advance;
            if (gnt_any && !advance) begin
                hold_gnt <= gnt;
            end
            if (advance) begin
                gnt_d <= gnt;
                if (gnt_any) begin
                    ptr <= gnt_idx;
                    if (gnt_idx == ptr) begin
                        if (hold_cnt != CNT_CAP) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_cnt <= CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef AHBL_RR_LOCK_EN
    // Enter a locked sequence when a locking master wins. Leave it when that
    // master completes a phase that is not locked, or stops requesting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q  <= 1'b0;
            lock_id <= '0;
        end else if (advance) begin
            if (lock_q) begin
                if (!mastlock[lock_id] || !req[lock_id]) begin
                    lock_q <= 1'b0;
                end
            end else if (gnt_any && mastlock[gnt_idx]) begin
                lock_q  <= 1'b1;
                lock_id <= gnt_idx;
            end
        end
    end
`endif

endmodule

// File: doc/ahbl_rr_sched.md
AHBL_RR_SCHED -- requirements
Module: ahbl_rr_sched

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requesting masters (legal 2..8).
REQ-002 SHALL have parameter CONN_MASK, default {N_PORTS{1'b1}}, per-port connectivity; a 0 bit means that port is never granted.
REQ-003 SHALL have parameter MAX_HOLD, default 4, consecutive accepted grants to one port before forced rotation; 0 disables the limit.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port req, input, N_PORTS, per-port address-phase request (HTRANS[1] of the port's actual request).
REQ-007 SHALL have port mastlock, input, N_PORTS, per-port HMASTLOCK.
REQ-008 SHALL have port advance, input, 1, the downstream address phase completes this cycle (dst HREADY high).
REQ-009 SHALL have port gnt, output, N_PORTS, one-hot or zero address-phase grant; combinational.
REQ-010 SHALL have port gnt_d, output, N_PORTS, registered data-phase owner.
REQ-011 SHALL have port locked, output, 1, the locked sequence is in force.

Function
REQ-012 SHALL form eligible = req & CONN_MASK; gnt SHALL be 0 when eligible is 0.
REQ-013 SHALL search eligible cyclically, starting at ptr+1 mod N_PORTS, and grant the first eligible port; ptr is the index of the last accepted grant.
REQ-014 SHALL exclude the ptr port from the search when hold_cnt equals MAX_HOLD, MAX_HOLD is nonzero, and another port is eligible.
REQ-015 SHALL hold a presented grant while advance is low:
- if gnt is nonzero and advance is low, that grant is registered as hold_gnt with hold_valid set;
- while hold_valid is set and that port's req remains high, gnt equals hold_gnt regardless of other requests;
- hold_valid clears on advance, or when the held port drops req.
REQ-016 SHALL, on advance with gnt nonzero:
- set ptr to the granted index;
- set gnt_d to gnt;
- set hold_cnt to hold_cnt+1 (saturating at MAX_HOLD) if the port is the same as ptr, otherwise to 1.
REQ-017 SHALL, on advance with gnt zero, set gnt_d to 0 and leave ptr and hold_cnt unchanged.
REQ-018 SHALL leave gnt_d, ptr and hold_cnt unchanged while advance is low.
REQ-019 SHALL apply precedence for gnt as lock (REQ-020), then hold (REQ-015), then the round-robin search (REQ-013/014).
REQ-020 SHALL handle locked sequences (when compiled in):
- on advance granting port k with mastlock[k]=1, locked sets and lock_id becomes k;
- while locked, gnt is req[k] ? onehot(k) : 0, and MAX_HOLD is ignored;
- locked clears on advance when mastlock[k]=0 or req[k]=0.
REQ-021 SHALL ensure gnt and gnt_d are never multi-hot, and a port with CONN_MASK=0 never appears in either.

Reset
REQ-022 SHALL, while rst_n is low at a clock edge, set the following state:
- gnt_d=0, locked=0, hold_valid=0, hold_cnt=0;
- ptr=N_PORTS-1, so that port 0 is searched first after reset.
REQ-023 SHALL give reset mid-transfer (advance low, hold_valid set) priority over every other update; the next cycle arbitrates from reset state.
REQ-024 SHALL have gnt depend only on reset state and inputs in the cycle after reset.

Configuration
REQ-025 SHALL honour macro AHBL_RR_LOCK_EN:
- defined: REQ-020 is implemented and the locked output reflects lock state;
- undefined: mastlock is ignored, locked is tied 0, and no lock registers exist.

Verification
REQ-026 SHALL cover each scenario below with N_PORTS=3, MAX_HOLD=2, AHBL_RR_LOCK_EN defined unless noted:
- Reset, then req=3'b111, advance=1 for 3 cycles -> gnt sequence 001, 010, 100; gnt_d lags gnt by one cycle.
- req=3'b001 only, advance=1 for 4 cycles -> gnt=001 every cycle (no other requester, so no forced rotation); hold_cnt saturates at 2.
- req=3'b011 with ptr=0 and hold_cnt=2 -> gnt=010; then req=3'b001 -> gnt=001 and hold_cnt=1.
- gnt=010 with advance=0 for 3 cycles while req[0] rises -> gnt stays 010 until advance; then gnt_d=010.
- Port 2 granted with mastlock=1 and req=3'b111 for 4 cycles -> gnt=100 throughout and locked=1; mastlock[2]=0 with advance -> locked=0 on the next cycle, then gnt=001.
- Same stimulus with AHBL_RR_LOCK_EN undefined -> round-robin continues and locked=0; CONN_MASK=3'b101 with req=3'b010 -> gnt=000.
